// File: rtl/ccx_ic_router.sv
// ccx_ic_router: one-requestor, two-responder address-decode router with registered response steering.
// Build option CCX_IC_ROUTER_ERR_EN: unmapped requests are absorbed by an internal error responder
// (granted at once, answered with err=1) and counted in unmapped_count; without it port 1 is the default
// responder for unmapped addresses and unmapped_count stays 0.
module ccx_ic_router #(
  parameter int AW = 39,
  parameter int DW = 64,
  parameter logic [AW-1:0] R0_BASE = 39'h00_0000_0000,
  parameter logic [AW-1:0] R0_MASK = 39'h7F_FFFF_0000,
  parameter logic [AW-1:0] R1_BASE = 39'h00_1000_0000,
  parameter logic [AW-1:0] R1_MASK = 39'h7F_F000_0000
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            req_req,
  input  logic [AW-1:0]   req_addr,
  input  logic            req_wen,
  input  logic [DW/8-1:0] req_strb,
  input  logic [DW-1:0]   req_wdata,
  output logic            req_gnt,
  output logic            req_err,
  output logic [DW-1:0]   req_rdata,
  output logic            rsp_0_req,
  output logic [AW-1:0]   rsp_0_addr,
  output logic            rsp_0_wen,
  output logic [DW/8-1:0] rsp_0_strb,
  output logic [DW-1:0]   rsp_0_wdata,
  input  logic            rsp_0_gnt,
  input  logic            rsp_0_err,
  input  logic [DW-1:0]   rsp_0_rdata,
  output logic            rsp_1_req,
  output logic [AW-1:0]   rsp_1_addr,
  output logic            rsp_1_wen,
  output logic [DW/8-1:0] rsp_1_strb,
  output logic [DW-1:0]   rsp_1_wdata,
  input  logic            rsp_1_gnt,
  input  logic            rsp_1_err,
  input  logic [DW-1:0]   rsp_1_rdata,
  output logic [15:0]     unmapped_count
);
  typedef enum logic [1:0] {NONE, P0, P1, ERR} sel_t;
`ifdef CCX_IC_ROUTER_ERR_EN
  localparam logic ERR_GNT = 1'b1;
`else
  localparam logic ERR_GNT = 1'b0;
`endif
  sel_t rsp_sel, sel_next;
  logic hit0, win1, hit1, miss;
  assign hit0 = (req_addr & R0_MASK) == R0_BASE;
  assign win1 = (req_addr & R1_MASK) == R1_BASE;
  // Without the error responder, anything not claimed by port 0 falls through to port 1.
  assign hit1 = !hit0 && (win1 || !ERR_GNT);
  assign miss = !hit0 && !hit1;
  assign rsp_0_req = req_req && hit0;
  assign rsp_1_req = req_req && hit1;
  assign {rsp_0_addr, rsp_0_wen, rsp_0_strb, rsp_0_wdata} = {req_addr, req_wen, req_strb, req_wdata};
  assign {rsp_1_addr, rsp_1_wen, rsp_1_strb, rsp_1_wdata} = {req_addr, req_wen, req_strb, req_wdata};
  assign req_gnt = (hit0 && rsp_0_gnt) || (hit1 && rsp_1_gnt) || (miss && ERR_GNT);
  // Remember which target owes the response due next cycle.
  always_ff @(posedge g_clk)
    if (g_reset) rsp_sel <= NONE;
    else rsp_sel <= sel_next;
  // Next routing target and response mux driven from the current routing state.
  always_comb begin
    sel_next = (req_req && req_gnt) ? (hit0 ? P0 : hit1 ? P1 : ERR) : NONE;
    req_rdata = rsp_sel == P0 ? rsp_0_rdata : rsp_sel == P1 ? rsp_1_rdata : '0;
    req_err = rsp_sel == P0 ? rsp_0_err : rsp_sel == P1 ? rsp_1_err : rsp_sel == ERR;
  end
`ifdef CCX_IC_ROUTER_ERR_EN
  // Saturating count of requests absorbed by the error responder.
  always_ff @(posedge g_clk)
    if (g_reset) unmapped_count <= '0;
    else if (req_req && miss && unmapped_count != 16'hFFFF) unmapped_count <= unmapped_count + 16'd1;
`else
  assign unmapped_count = '0;
`endif
endmodule

// File: tb/tb_ccx_ic_router.sv
// tb_ccx_ic_router: directed and randomized checks of ccx_ic_router against a transaction-level model.
module tb_ccx_ic_router;
  localparam logic [38:0] R0_BASE = 39'h00_0000_0000;
  localparam logic [38:0] R0_MASK = 39'h7F_FFFF_0000;
  localparam logic [38:0] R1_BASE = 39'h00_1000_0000;
  localparam logic [38:0] R1_MASK = 39'h7F_F000_0000;
`ifdef CCX_IC_ROUTER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic g_clk = 1'b0, g_reset = 1'b1;
  logic req_req = 1'b0, req_wen = 1'b0;
  logic [38:0] req_addr = '0;
  logic [7:0] req_strb = '0;
  logic [63:0] req_wdata = '0;
  logic req_gnt, req_err;
  logic [63:0] req_rdata;
  logic rsp_0_req, rsp_0_wen, rsp_1_req, rsp_1_wen;
  logic [38:0] rsp_0_addr, rsp_1_addr;
  logic [7:0] rsp_0_strb, rsp_1_strb;
  logic [63:0] rsp_0_wdata, rsp_1_wdata;
  logic rsp_0_gnt = 1'b0, rsp_0_err = 1'b0, rsp_1_gnt = 1'b0, rsp_1_err = 1'b0;
  logic [63:0] rsp_0_rdata = '0, rsp_1_rdata = '0;
  logic [15:0] unmapped_count;
  int checks = 0, errors = 0;

  ccx_ic_router dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .req_req(req_req), .req_addr(req_addr), .req_wen(req_wen), .req_strb(req_strb), .req_wdata(req_wdata),
    .req_gnt(req_gnt), .req_err(req_err), .req_rdata(req_rdata),
    .rsp_0_req(rsp_0_req), .rsp_0_addr(rsp_0_addr), .rsp_0_wen(rsp_0_wen), .rsp_0_strb(rsp_0_strb),
    .rsp_0_wdata(rsp_0_wdata), .rsp_0_gnt(rsp_0_gnt), .rsp_0_err(rsp_0_err), .rsp_0_rdata(rsp_0_rdata),
    .rsp_1_req(rsp_1_req), .rsp_1_addr(rsp_1_addr), .rsp_1_wen(rsp_1_wen), .rsp_1_strb(rsp_1_strb),
    .rsp_1_wdata(rsp_1_wdata), .rsp_1_gnt(rsp_1_gnt), .rsp_1_err(rsp_1_err), .rsp_1_rdata(rsp_1_rdata),
    .unmapped_count(unmapped_count)
  );

  always #5 g_clk = ~g_clk;

  // Target of an address: 0 = port 0, 1 = port 1, 2 = error responder.
  function automatic int target(input logic [38:0] a);
    if ((a & R0_MASK) == R0_BASE) return 0;
    if ((a & R1_MASK) == R1_BASE) return 1;
    return ERR_EN ? 2 : 1;
  endfunction

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic idle();
    req_req = 1'b0; rsp_0_gnt = 1'b0; rsp_1_gnt = 1'b0; rsp_0_err = 1'b0; rsp_1_err = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    g_reset = 1'b1;
    tick();
    g_reset = 1'b0;
  endtask

  task automatic test_reset();
    g_reset = 1'b1;
    req_req = 1'b1; req_addr = 39'h100;
    #1;
    checks++;
    if (rsp_0_req !== 1'b1 || rsp_1_req !== 1'b0) begin
      errors++; $display("FAIL reset_comb_req: got %b%b want 10", rsp_0_req, rsp_1_req);
    end
    idle();
    tick(); tick();
    g_reset = 1'b0;
    rsp_0_rdata = 64'h1234; rsp_0_err = 1'b1;
    tick();
    checks++;
    if (req_err !== 1'b0 || req_rdata !== 64'h0 || unmapped_count !== 16'h0) begin
      errors++; $display("FAIL reset_state: err=%b rdata=%h cnt=%h want 0/0/0", req_err, req_rdata, unmapped_count);
    end
    idle();
  endtask

  task automatic test_read_p0();
    tick();
    req_req = 1'b1; req_addr = 39'h100; req_wen = 1'b0; rsp_0_gnt = 1'b1;
    #1;
    checks++;
    if (rsp_0_req !== 1'b1 || rsp_1_req !== 1'b0 || req_gnt !== 1'b1) begin
      errors++; $display("FAIL read_p0_req: r0=%b r1=%b gnt=%b want 1/0/1", rsp_0_req, rsp_1_req, req_gnt);
    end
    tick();
    idle();
    rsp_0_rdata = 64'hDEAD_BEEF_0000_0001; rsp_1_rdata = 64'h5555;
    #1;
    checks++;
    if (req_rdata !== 64'hDEAD_BEEF_0000_0001 || req_err !== 1'b0) begin
      errors++; $display("FAIL read_p0_rsp: rdata=%h err=%b want deadbeef00000001/0", req_rdata, req_err);
    end
  endtask

  task automatic test_write_stall();
    logic [63:0] wd, rd;
    wd = {$urandom, $urandom};
    rd = {$urandom, $urandom};
    tick();
    req_req = 1'b1; req_addr = 39'h1000_0040; req_wen = 1'b1; req_strb = 8'h0F; req_wdata = wd; rsp_1_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (req_gnt !== 1'b0 || rsp_1_req !== 1'b1 || rsp_0_req !== 1'b0 || rsp_1_addr !== 39'h1000_0040 ||
          rsp_1_strb !== 8'h0F || rsp_1_wen !== 1'b1 || rsp_1_wdata !== wd) begin
        errors++; $display("FAIL write_stall_%0d: gnt=%b r1=%b addr=%h strb=%h want 0/1/1000_0040/0f", i, req_gnt, rsp_1_req, rsp_1_addr, rsp_1_strb);
      end
      tick();
      checks++;
      if (req_err !== 1'b0 || req_rdata !== 64'h0) begin
        errors++; $display("FAIL write_stall_rsp_%0d: err=%b rdata=%h want 0/0", i, req_err, req_rdata);
      end
    end
    rsp_1_gnt = 1'b1;
    #1;
    checks++;
    if (req_gnt !== 1'b1) begin
      errors++; $display("FAIL write_gnt: got %b want 1", req_gnt);
    end
    tick();
    idle();
    rsp_1_rdata = rd; rsp_0_rdata = ~rd;
    #1;
    checks++;
    if (req_rdata !== rd || req_err !== 1'b0) begin
      errors++; $display("FAIL write_rsp: rdata=%h err=%b want %h/0", req_rdata, req_err, rd);
    end
  endtask

  task automatic test_back_to_back();
    tick();
    req_req = 1'b1; req_addr = 39'h200; req_wen = 1'b0; rsp_0_gnt = 1'b1; rsp_1_gnt = 1'b0;
    tick();
    req_addr = 39'h1000_0000; rsp_0_gnt = 1'b0; rsp_1_gnt = 1'b1;
    rsp_0_rdata = 64'hA0A0; rsp_0_err = 1'b0; rsp_1_rdata = 64'hB1B1; rsp_1_err = 1'b1;
    #1;
    checks++;
    if (req_err !== 1'b0 || req_rdata !== 64'hA0A0 || req_gnt !== 1'b1) begin
      errors++; $display("FAIL b2b_n1: err=%b rdata=%h gnt=%b want 0/a0a0/1", req_err, req_rdata, req_gnt);
    end
    tick();
    idle();
    rsp_1_err = 1'b1; rsp_1_rdata = 64'hC2C2; rsp_0_rdata = 64'hD3D3;
    #1;
    checks++;
    if (req_err !== 1'b1 || req_rdata !== 64'hC2C2) begin
      errors++; $display("FAIL b2b_n2: err=%b rdata=%h want 1/c2c2", req_err, req_rdata);
    end
  endtask

  task automatic test_unmapped();
    do_reset();
    req_req = 1'b1; req_addr = 39'h4000_0000; rsp_0_gnt = 1'b1; rsp_1_gnt = ERR_EN ? 1'b0 : 1'b1;
    #1;
    checks++;
    if (req_gnt !== 1'b1 || rsp_0_req !== 1'b0 || rsp_1_req !== !ERR_EN) begin
      errors++; $display("FAIL unmapped_req: gnt=%b r0=%b r1=%b want 1/0/%b", req_gnt, rsp_0_req, rsp_1_req, !ERR_EN);
    end
    tick();
    idle();
    rsp_0_rdata = 64'h77; rsp_1_rdata = 64'h99;
    #1;
    checks++;
    if (req_err !== ERR_EN || req_rdata !== (ERR_EN ? 64'h0 : 64'h99) || unmapped_count !== 16'(ERR_EN)) begin
      errors++; $display("FAIL unmapped_rsp: err=%b rdata=%h cnt=%h want %b/%h/%h", req_err, req_rdata, unmapped_count, ERR_EN, ERR_EN ? 64'h0 : 64'h99, 16'(ERR_EN));
    end
  endtask

  task automatic test_reset_mid();
    tick();
    req_req = 1'b1; req_addr = 39'h300; rsp_0_gnt = 1'b1; g_reset = 1'b1;
    tick();
    g_reset = 1'b0;
    idle();
    rsp_0_err = 1'b1; rsp_0_rdata = 64'hFFFF;
    #1;
    checks++;
    if (req_err !== 1'b0 || req_rdata !== 64'h0 || unmapped_count !== 16'h0) begin
      errors++; $display("FAIL reset_mid: err=%b rdata=%h cnt=%h want 0/0/0", req_err, req_rdata, unmapped_count);
    end
    idle();
  endtask

  task automatic test_random();
    int pend;
    logic [15:0] cnt;
    logic [63:0] r;
    logic g;
    int t;
    do_reset();
    pend = -1; cnt = '0;
    for (int i = 0; i < 400; i++) begin
      r = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: req_addr = R0_BASE | 39'(r[15:0]);
        1: req_addr = R1_BASE | 39'(r[27:0]);
        2: req_addr = r[38:0];
        default: req_addr = 39'h4000_0000 | 39'(r[27:0]);
      endcase
      req_req = $urandom_range(0, 3) != 0; req_wen = r[40]; req_strb = r[48:41]; req_wdata = {$urandom, $urandom};
      rsp_0_gnt = $urandom_range(0, 1) != 0; rsp_1_gnt = $urandom_range(0, 1) != 0;
      rsp_0_err = $urandom_range(0, 1) != 0; rsp_1_err = $urandom_range(0, 1) != 0;
      rsp_0_rdata = {$urandom, $urandom}; rsp_1_rdata = {$urandom, $urandom};
      #1;
      t = target(req_addr);
      g = t == 0 ? rsp_0_gnt : t == 1 ? rsp_1_gnt : 1'b1;
      checks++;
      if (rsp_0_req !== (req_req && t == 0) || rsp_1_req !== (req_req && t == 1) || req_gnt !== g ||
          rsp_0_addr !== req_addr || rsp_1_strb !== req_strb || rsp_0_wdata !== req_wdata) begin
        errors++; $display("FAIL rand_req_%0d: addr=%h r0=%b r1=%b gnt=%b want tgt=%0d gnt=%b", i, req_addr, rsp_0_req, rsp_1_req, req_gnt, t, g);
      end
      checks++;
      if (req_rdata !== (pend == 0 ? rsp_0_rdata : pend == 1 ? rsp_1_rdata : 64'h0) ||
          req_err !== (pend == 0 ? rsp_0_err : pend == 1 ? rsp_1_err : pend == 2)) begin
        errors++; $display("FAIL rand_rsp_%0d: rdata=%h err=%b pending=%0d", i, req_rdata, req_err, pend);
      end
      checks++;
      if (unmapped_count !== cnt) begin
        errors++; $display("FAIL rand_cnt_%0d: got %h want %h", i, unmapped_count, cnt);
      end
      pend = (req_req && g) ? t : -1;
      if (req_req && t == 2 && cnt != 16'hFFFF) cnt++;
      tick();
    end
    idle();
  endtask

`ifdef CCX_IC_ROUTER_ERR_EN
  task automatic test_saturate();
    do_reset();
    req_req = 1'b1; req_addr = 39'h4000_0000;
    repeat (65537) @(posedge g_clk);
    #1;
    checks++;
    if (unmapped_count !== 16'hFFFF) begin
      errors++; $display("FAIL sat_reach: got %h want ffff", unmapped_count);
    end
    repeat (3) @(posedge g_clk);
    #1;
    checks++;
    if (unmapped_count !== 16'hFFFF) begin
      errors++; $display("FAIL sat_hold: got %h want ffff", unmapped_count);
    end
    idle();
  endtask
`endif

  initial begin
    test_reset();
    test_read_p0();
    test_write_stall();
    test_back_to_back();
    test_unmapped();
    test_reset_mid();
    test_random();
`ifdef CCX_IC_ROUTER_ERR_EN
    test_saturate();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
